// File: rtl/uart_pkg.sv
// Shared types for the UART receive path: parity selection and receiver FSM states.
package uart_pkg;

   typedef enum logic [1:0] {
      PAR_NONE,
      PAR_EVEN,
      PAR_ODD
   } parity_e;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PAR,
      STOP,
      WAIT_HIGH
   } rx_state_e;

   localparam logic [15:0] MIN_CLKDIV = 16'd3;

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO; a push is accepted when not full or when a pop frees a slot.
module sync_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         wdata,
   output logic [WIDTH-1:0]         rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [AW:0]      cnt_q;
   logic             do_push, do_pop;

   assign empty   = (cnt_q == '0);
   assign full    = (cnt_q == (AW+1)'(DEPTH));
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign count   = cnt_q;
   // Head reads as zero while empty so the output is defined straight out of reset.
   assign rdata   = empty ? '0 : mem[rd_ptr_q];

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
         case ({do_push, do_pop})
            2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
            2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
            default: cnt_q <= cnt_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr_q] <= wdata;
   end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receiver with optional parity, sticky error flags and a show-ahead receive FIFO.
module uart_rx_fifo
   import uart_pkg::*;
#(
   parameter int unsigned DATA_BITS = 8,
   parameter int unsigned DEPTH     = 4,
   parameter parity_e     PARITY    = PAR_NONE
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [15:0]              clkdiv,
   input  logic                     rx,
   input  logic                     rd_en,
   output logic [DATA_BITS-1:0]     rd_data,
   output logic                     rd_valid,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     frame_err,
   output logic                     parity_err,
   output logic                     overrun,
   input  logic                     err_clr
);

   localparam int unsigned BCW = $clog2(DATA_BITS);
   localparam logic [BCW-1:0] LAST_BIT = BCW'(DATA_BITS - 1);

   rx_state_e            state_q, state_d;
   logic [15:0]          timer_q, timer_d, div;
   logic [BCW-1:0]       bit_cnt_q, bit_cnt_d;
   logic [DATA_BITS-1:0] shreg_q, shreg_d;
   logic                 par_bad_q, par_bad_d;
   logic                 sync1_q, rx_s;
   logic                 push, set_frame, set_par, tick, half;
   logic                 full, empty;

   assign div  = (clkdiv < MIN_CLKDIV) ? MIN_CLKDIV : clkdiv;
   assign tick = (timer_q == div);
   assign half = (timer_q == (div >> 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q   <= 1'b1;
         rx_s      <= 1'b1;
         state_q   <= IDLE;
         timer_q   <= '0;
         bit_cnt_q <= '0;
         shreg_q   <= '0;
         par_bad_q <= 1'b0;
      end else begin
         sync1_q   <= rx;
         rx_s      <= sync1_q;
         state_q   <= state_d;
         timer_q   <= timer_d;
         bit_cnt_q <= bit_cnt_d;
         shreg_q   <= shreg_d;
         par_bad_q <= par_bad_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      timer_d   = timer_q;
      bit_cnt_d = bit_cnt_q;
      shreg_d   = shreg_q;
      par_bad_d = par_bad_q;
      push      = 1'b0;
      set_frame = 1'b0;
      set_par   = 1'b0;
      case (state_q)
         IDLE: begin
            if (!rx_s) begin
               state_d   = START;
               timer_d   = '0;
               bit_cnt_d = '0;
               par_bad_d = 1'b0;
            end
         end
         START: begin
            // Mid-start-bit resample rejects glitches shorter than half a bit.
            if (half) begin
               timer_d = '0;
               state_d = rx_s ? IDLE : DATA;
            end else begin
               timer_d = timer_q + 16'd1;
            end
         end
         DATA: begin
            if (tick) begin
               timer_d   = '0;
               shreg_d   = {rx_s, shreg_q[DATA_BITS-1:1]};
               bit_cnt_d = bit_cnt_q + BCW'(1);
               if (bit_cnt_q == LAST_BIT) state_d = (PARITY == PAR_NONE) ? STOP : PAR;
            end else begin
               timer_d = timer_q + 16'd1;
            end
         end
         PAR: begin
            if (tick) begin
               timer_d   = '0;
               par_bad_d = ((^shreg_q) ^ rx_s) != (PARITY == PAR_ODD);
               state_d   = STOP;
            end else begin
               timer_d = timer_q + 16'd1;
            end
         end
         STOP: begin
            if (tick) begin
               timer_d = '0;
               set_par = par_bad_q;
               if (rx_s) begin
                  push    = !par_bad_q;
                  state_d = IDLE;
               end else begin
                  set_frame = 1'b1;
                  state_d   = WAIT_HIGH;
               end
            end else begin
               timer_d = timer_q + 16'd1;
            end
         end
         WAIT_HIGH: begin
            if (rx_s) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // A set in the same cycle as err_clr wins.
   always_ff @(posedge clk) begin
      if (rst) begin
         frame_err  <= 1'b0;
         parity_err <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         frame_err  <= (frame_err  & ~err_clr) | set_frame;
         parity_err <= (parity_err & ~err_clr) | set_par;
         overrun    <= (overrun    & ~err_clr) | (push & full & ~rd_en);
      end
   end

   assign rd_valid = !empty;

   sync_fifo #(
      .WIDTH (DATA_BITS),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (rd_en),
      .wdata (shreg_q),
      .rdata (rd_data),
      .full  (full),
      .empty (empty),
      .count (count)
   );

endmodule
